// File: rtl/apb_fill_engine.sv
// ----------------------------------------------------------------------------
// apb_fill_engine
//
// Command executor placed behind apb3_slave. On an accepted start it writes
// ilen words of an incrementing pattern (address step 4, data step 1) to a
// memory-side write port. It then reports done or error on status and pulses
// irq for one cycle.
//
// Parameters
//   TIMEOUT_CYC  consecutive stall cycles tolerated before the command errors (>=1)
//
// Ports
//   clk, resetn          system clock, asynchronous active-low reset
//   start                command strobe, sampled each clk; ignored while busy
//   iaddr, ilen, idata   byte start address (4-byte aligned), word count
//                        (1..255), data of word 0
//   abort                cancels a running command
//   status               00 idle, 01 busy, 10 done, 11 error (the FSM state itself)
//   irq                  one-cycle pulse on entry to done or error
//   wr_valid/wr_ready    write port handshake
//   wr_addr/wr_data      address and data of the word being offered
//   words_done           handshakes completed for the current or last command
//
// Write port handshake: a word transfers on a rising clk where
// wr_valid & wr_ready. While wr_valid is high and wr_ready is low, wr_addr and
// wr_data hold. wr_valid never drops without a transfer, except on an error
// exit (abort or stall timeout).
// ----------------------------------------------------------------------------
module apb_fill_engine #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] iaddr,
    input  logic [7:0]  ilen,
    input  logic [31:0] idata,
    input  logic        abort,
    output logic [1:0]  status,
    output logic        irq,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_ready,
    output logic [7:0]  words_done
);

    localparam int unsigned    CW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  STALL_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    state_t         state_q;
    logic           irq_q;
    logic           wr_valid_q;
    logic [31:0]    wr_addr_q;
    logic [31:0]    wr_data_q;
    logic [7:0]     words_done_q;
    logic [7:0]     len_q;
    logic [CW-1:0]  stall_q;

    logic [7:0]     words_done_d;
    logic [7:0]     ilen_m1;
    logic [32:0]    end_addr;
    logic           cmd_bad;
    logic           hs;
    logic           last_word;

    always_comb begin
        ilen_m1      = ilen - 8'd1;
        // Address of the final word, with a carry bit to catch 32-bit wrap.
        end_addr     = {1'b0, iaddr} + {23'd0, ilen_m1, 2'b00};
        cmd_bad      = (ilen == 8'd0) || (iaddr[1:0] != 2'b00) || end_addr[32];
        hs           = wr_valid_q && wr_ready;
        words_done_d = words_done_q + 8'd1;
        last_word    = (words_done_d == len_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            irq_q        <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 32'd0;
            wr_data_q    <= 32'd0;
            words_done_q <= 8'd0;
            len_q        <= 8'd0;
            stall_q      <= '0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (!wr_valid_q) begin
                        // All words have transferred. This is the closing cycle
                        // that makes done appear N+1 cycles after accept.
                        state_q <= S_DONE;
                        irq_q   <= 1'b1;
                    end else if (hs) begin
                        words_done_q <= words_done_d;
                        stall_q      <= '0;
                        if (last_word) begin
                            // The final word wins over a same-edge abort.
                            wr_valid_q <= 1'b0;
                        end else if (abort) begin
                            state_q    <= S_ERR;
                            irq_q      <= 1'b1;
                            wr_valid_q <= 1'b0;
                        end else begin
                            wr_addr_q <= wr_addr_q + 32'd4;
                            wr_data_q <= wr_data_q + 32'd1;
                        end
                    end else if (abort || (stall_q == STALL_LAST)) begin
                        // Abort or stall timeout. wr_valid drops without a transfer.
                        state_q    <= S_ERR;
                        irq_q      <= 1'b1;
                        wr_valid_q <= 1'b0;
                    end else begin
                        stall_q <= stall_q + CW'(1);
                    end
                end
                default: begin
                    // IDLE, DONE, ERR: start is accepted and abort is ignored.
                    if (start) begin
                        words_done_q <= 8'd0;
                        stall_q      <= '0;
                        len_q        <= ilen;
                        if (cmd_bad) begin
                            state_q <= S_ERR;
                            irq_q   <= 1'b1;
                        end else begin
                            state_q    <= S_RUN;
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= iaddr;
                            wr_data_q  <= idata;
                        end
                    end
                end
            endcase
        end
    end

    assign status     = state_q;
    assign irq        = irq_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_apb_fill_engine.sv
// ----------------------------------------------------------------------------
// tb_apb_fill_engine
//
// Bench for apb_fill_engine, with TIMEOUT_CYC set to 8.
//
// For each command the bench works out the expected outcome before driving
// anything. It uses the word count, the per-cycle wr_ready pattern and the
// abort cycle to produce:
//   - the list of words that must transfer (scoreboard queue),
//   - the cycle at which the command ends,
//   - the final status.
//
// A monitor pops the queue on every observed handshake. It also checks that
// wr_addr and wr_data hold through stalls.
// ----------------------------------------------------------------------------
module tb_apb_fill_engine;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic [7:0]  ilen = 8'd0;
  logic [31:0] idata = 32'd0;
  logic        abort = 1'b0;
  logic        wr_ready = 1'b0;
  logic [1:0]  status;
  logic        irq;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  words_done;

  apb_fill_engine #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .iaddr      (iaddr),
    .ilen       (ilen),
    .idata      (idata),
    .abort      (abort),
    .status     (status),
    .irq        (irq),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .words_done (words_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];       // {addr, data} of each expected transfer
  logic        pat [0:511];    // wr_ready per cycle after accept

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    logic [63:0] e;
    prev_stall = 1'b0;
    prev_addr  = 32'd0;
    prev_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && wr_valid) begin
          check_eq("stall_addr_hold", 64'(wr_addr), 64'(prev_addr));
          check_eq("stall_data_hold", 64'(wr_data), 64'(prev_data));
        end
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_write", {wr_addr, wr_data}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("wr_addr", 64'(wr_addr), 64'(e[63:32]));
            check_eq("wr_data", 64'(wr_data), 64'(e[31:0]));
          end
        end
        prev_stall = wr_valid && !wr_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_pat(input int pct);
    for (int i = 0; i < 512; i++) pat[i] = ($urandom_range(0, 99) < pct);
  endtask

  // Runs one command. Call at posedge+1. Returns at posedge+1.
  task automatic run_cmd(input logic [31:0] a, input logic [7:0] n, input logic [31:0] d,
                         input int abort_c, input int srun_c, input logic abort_at_accept);
    int          k;
    int          stall;
    int          end_c;
    logic        bad;
    logic [1:0]  fin_st;
    logic [63:0] last_addr;

    last_addr = {32'd0, a} + 64'(4 * int'(n)) - 64'd4;
    bad    = (n == 8'd0) || (a[1:0] != 2'b00) || (last_addr > 64'hFFFF_FFFF);
    k      = 0;
    end_c  = 0;
    fin_st = 2'b11;
    if (!bad) begin
      end_c = -1;
      stall = 0;
      for (int c = 0; c < 500 && end_c < 0; c++) begin
        if (pat[c]) begin
          exp_q.push_back({a + 32'(4 * k), d + 32'(k)});
          k++;
          stall = 0;
          if (k == int'(n)) begin
            end_c  = c + 2;
            fin_st = 2'b10;
          end else if (c == abort_c) begin
            end_c = c + 1;
          end
        end else if (c == abort_c) begin
          end_c = c + 1;
        end else begin
          stall++;
          if (stall == TO) end_c = c + 1;
        end
      end
    end

    // Accept edge
    iaddr    = a;
    ilen     = n;
    idata    = d;
    start    = 1'b1;
    abort    = abort_at_accept;
    wr_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;

    for (int c = 0; c <= end_c; c++) begin
      wr_ready = pat[c];
      abort    = (c == abort_c);
      start    = (c == srun_c) && (c < end_c);
      if (start) begin
        iaddr = $urandom;
        ilen  = 8'($urandom);
        idata = $urandom;
      end
      @(negedge clk);
      check_eq("status", 64'(status), 64'((c == end_c) ? fin_st : 2'b01));
      check_eq("irq", 64'(irq), 64'(c == end_c));
      if (c == 0 && !bad) check_eq("words_done_cleared", 64'(words_done), 64'd0);
      @(posedge clk); #1;
    end

    start    = 1'b0;
    abort    = 1'b0;
    wr_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("status_hold", 64'(status), 64'(fin_st));
    check_eq("irq_low_after", 64'(irq), 64'd0);
    check_eq("wr_valid_low_after", 64'(wr_valid), 64'd0);
    check_eq("words_done", 64'(words_done), 64'(k));
    check_eq("pending_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [7:0]  n;
    int          pct;
    int          ab;
    int          sr;
    int          sel;

    #23;
    check_eq("rst_status", 64'(status), 64'd0);
    check_eq("rst_irq", 64'(irq), 64'd0);
    check_eq("rst_wr_valid", 64'(wr_valid), 64'd0);
    check_eq("rst_wr_addr", 64'(wr_addr), 64'd0);
    check_eq("rst_wr_data", 64'(wr_data), 64'd0);
    check_eq("rst_words_done", 64'(words_done), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Pattern data wrapping through zero, full-rate sink
    fill_pat(100);
    run_cmd(32'h1000, 8'd4, 32'hFFFF_FFFE, -1, -1, 1'b0);

    // Rejected commands, plus the boundary case that just fits
    run_cmd(32'h1000, 8'd0, 32'h5, -1, -1, 1'b0);
    run_cmd(32'h1002, 8'd3, 32'h5, -1, -1, 1'b0);
    run_cmd(32'hFFFF_FFFC, 8'd2, 32'h5, -1, -1, 1'b0);
    run_cmd(32'hFFFF_FFFC, 8'd1, 32'hABCD, -1, -1, 1'b1);

    // Stalls: wr_ready 0,1,0,0,1,1
    fill_pat(100);
    pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0;
    pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b1;
    run_cmd(32'h2000, 8'd3, 32'h10, -1, -1, 1'b0);

    // Stall timeout
    fill_pat(0);
    run_cmd(32'h3000, 8'd2, 32'h20, -1, -1, 1'b0);

    // Abort on the edge of the 4th handshake; start during RUN is ignored
    fill_pat(100);
    run_cmd(32'h4000, 8'd10, 32'h30, 3, 1, 1'b0);

    // Abort coinciding with the final word: done wins
    run_cmd(32'h4100, 8'd3, 32'h40, 2, -1, 1'b0);

    // Asynchronous reset in the middle of a command
    for (int k = 0; k < 10; k++) exp_q.push_back({32'h5000 + 32'(4 * k), 32'h77 + 32'(k)});
    iaddr = 32'h5000; ilen = 8'd10; idata = 32'h77; start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_eq("arst_status", 64'(status), 64'd0);
    check_eq("arst_irq", 64'(irq), 64'd0);
    check_eq("arst_wr_valid", 64'(wr_valid), 64'd0);
    check_eq("arst_wr_addr", 64'(wr_addr), 64'd0);
    check_eq("arst_wr_data", 64'(wr_data), 64'd0);
    check_eq("arst_words_done", 64'(words_done), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    fill_pat(100);
    run_cmd(32'h6000, 8'd5, 32'h99, -1, -1, 1'b0);

    // Randomized commands
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom | 32'h1;
      else if (sel == 1) a = 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 20));
      else               a = $urandom & 32'hFFFF_FFFC;
      n = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
      case ($urandom_range(0, 2))
        0:       pct = 100;
        1:       pct = 75;
        default: pct = 45;
      endcase
      fill_pat(pct);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * int'(n) + 2) : -1;
      sr = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1;
      run_cmd(a, n, $urandom, ab, sr, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
